div_repsub: RTL and testbench
=============================

// Module: div_repsub
// PURPOSE
//  Unsigned integer divider using repeated subtraction; the inverse companion of the
//  repeated-addition multiplier. Holds the remainder and quotient registers, a
//  comparator and a subtractor, plus the FSM that sequences them.
//  The block sits beside the multiplier and uses the same start/done handshake.
// PARAMETERS
//  WIDTH  16  operand, quotient and remainder width (bits); WIDTH >= 2
// PORTS
//  clk          in   1      clock; all state updates on the rising edge
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      request; sampled only in IDLE or DONE
//  dividend     in   WIDTH  unsigned dividend; sampled on the accepted start edge
//  divisor      in   WIDTH  unsigned divisor; sampled on the accepted start edge
//  busy         out  1      high while in RUN
//  done         out  1      result valid (see BEHAVIOUR/CONFIGURATION)
//  quotient     out  WIDTH  registered quotient
//  remainder    out  WIDTH  registered remainder
//  div_by_zero  out  1      divisor was 0 for the current result
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; busy=done=div_by_zero=0; quotient=remainder=0.
//    Asserting rst mid-operation aborts the division immediately. No partial result is kept.
//  - All outputs are registered. There are no combinational paths from inputs to outputs.
//  - States: IDLE, RUN, DONE. Encoding is free.
//  - IDLE/DONE with start=1, at the edge:
//    - divisor!=0: remainder<=dividend, quotient<=0, div_by_zero<=0, done<=0; go to RUN.
//    - divisor==0: remainder<=dividend, quotient<={WIDTH{1'b1}}, div_by_zero<=1; go to DONE.
//  - RUN, each edge:
//    - remainder>=divisor_reg: remainder<=remainder-divisor_reg, quotient<=quotient+1.
//    - Otherwise: go to DONE with no register change.
//  - Latency: for quotient q, done is high after q+1 edges following the start edge.
//    For divide-by-zero, done is high after 1 edge.
//  - start while in RUN is ignored. Operands in flight are unaffected.
//  - Operand ports may change freely after the start edge, because divisor_reg holds the divisor.
//  - Arithmetic:
//    - Compare and subtract are unsigned, WIDTH bits. The subtract never underflows.
//    - The quotient never exceeds the dividend, so it never wraps.
//  - Boundaries:
//    - dividend<divisor: q=0, remainder=dividend, done after 1 edge.
//    - dividend=0, divisor!=0: q=0, r=0.
//    - dividend==divisor: q=1, r=0, done after 2 edges.
//  - quotient/remainder/div_by_zero hold their values in DONE and IDLE until the next accepted start.
// CONFIGURATION
//  DIV_DONE_PULSE_EN
//  - Undefined (default): DONE is sticky. done stays 1 until the next accepted start or rst.
//  - Defined: done is a single-cycle pulse. DONE lasts one cycle, then the FSM returns
//    to IDLE with done=0; results still hold. A start during that DONE cycle is accepted.
// TESTING
//  1. dividend=100, divisor=7 -> busy for 15 cycles; done after 15 edges; q=14, r=2, dbz=0.
//  2. dividend=5, divisor=9 -> done after 1 edge; q=0, r=5.
//  3. dividend=1234, divisor=0 -> done after 1 edge; dbz=1, q=16'hFFFF, r=1234.
//  4. dividend=16'hFFFF, divisor=1 -> q=16'hFFFF, r=0, done after 65536 edges.
//     dividend=9, divisor=9 -> q=1, r=0.
//  5. Start 200/3; pulse rst at cycle 10 -> all outputs 0, IDLE.
//     Then 30/4 -> q=7, r=2.
//     Start 50/5, hold start high and change operands during RUN -> q=10, r=0
//     (the second start is ignored).
//  6. Back-to-back 20/6 then 9/2 with start held in DONE -> q=3, r=2 then q=4, r=1.
//     Repeat the whole suite with DIV_DONE_PULSE_EN defined -> done is high for exactly 1 cycle.

Source files
------------

// File: rtl/div_repsub.sv
// Unsigned repeated-subtraction divider with a start/done handshake.
// Optional macro DIV_DONE_PULSE_EN: done becomes a one-cycle pulse instead of sticky.
module div_repsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Handshake: start is honoured only in IDLE or DONE. Operands are captured on
  // that edge. done stays high in DONE (sticky) or for one cycle (pulse build),
  // and the results hold until the next accepted start.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] divisor_reg;
  logic             accept;
  logic             step;
  logic             divisor_zero;

  assign divisor_zero = (divisor == '0);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = divisor_zero ? DONE : RUN;
        end else begin
`ifdef DIV_DONE_PULSE_EN
          state_next = IDLE;
`else
          state_next = state;
`endif
        end
      end
      RUN: begin
        if (remainder >= divisor_reg) begin
          step = 1'b1;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      divisor_reg <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      // Status flags are flopped copies of the next state, so no input reaches an output combinationally.
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      if (accept) begin
        remainder   <= dividend;
        divisor_reg <= divisor;
        if (divisor_zero) begin
          quotient    <= '1;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= '0;
          div_by_zero <= 1'b0;
        end
      end else if (step) begin
        remainder <= remainder - divisor_reg;
        quotient  <= quotient + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_repsub.sv
// Directed bench for div_repsub; build with +define+DIV_DONE_PULSE_EN for the pulse variant.
module tb_div_repsub;
  localparam int WIDTH  = 16;
  localparam int BUDGET = 70000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int checks   = 0;
  int failures = 0;

`ifdef DIV_DONE_PULSE_EN
  localparam logic DONE_AFTER = 1'b0;
`else
  localparam logic DONE_AFTER = 1'b1;
`endif

  div_repsub #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // edges counts rising edges after the start edge until done is seen;
  // busy_cycles counts sampled cycles with busy high in that window.
  task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int edges, output int busy_cycles);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    edges       = 0;
    busy_cycles = 0;
    while (!done && edges < BUDGET) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout %0d/%0d: done=%b after %0d edges", a, b, done, edges);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got busy/done/dbz=%b want 000", {busy, done, div_by_zero});
    end
    checks++;
    if (quotient !== '0 || remainder !== '0) begin
      failures++;
      $display("FAIL reset_data: got q=%0d r=%0d want 0 0", quotient, remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e, b;
    run_div(16'd100, 16'd7, e, b);
    checks++;
    if (e !== 15) begin failures++; $display("FAIL basic_latency: got %0d want 15", e); end
    checks++;
    if (b !== 15) begin failures++; $display("FAIL basic_busy: got %0d want 15", b); end
    checks++;
    if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b busy=%b want 14 2 0 0",
               quotient, remainder, div_by_zero, busy);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== DONE_AFTER || quotient !== 16'd14 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL done_shape: got done=%b q=%0d r=%0d want %b 14 2",
               done, quotient, remainder, DONE_AFTER);
    end
  endtask

  task automatic test_small();
    int e, b;
    run_div(16'd5, 16'd9, e, b);
    checks++;
    if (e !== 1 || quotient !== 16'd0 || remainder !== 16'd5 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL small: got edges=%0d q=%0d r=%0d dbz=%b want 1 0 5 0",
               e, quotient, remainder, div_by_zero);
    end
    run_div(16'd0, 16'd5, e, b);
    checks++;
    if (e !== 1 || quotient !== 16'd0 || remainder !== 16'd0) begin
      failures++;
      $display("FAIL zero_dividend: got edges=%0d q=%0d r=%0d want 1 0 0", e, quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int e, b;
    // Divide-by-zero finishes on the start edge itself: done is already high one edge in.
    run_div(16'd1234, 16'd0, e, b);
    checks++;
    if (e !== 0 || b !== 0) begin
      failures++;
      $display("FAIL dbz_latency: got edges=%0d busy=%0d want 0 0", e, b);
    end
    checks++;
    if (div_by_zero !== 1'b1 || quotient !== 16'hFFFF || remainder !== 16'd1234) begin
      failures++;
      $display("FAIL dbz_result: got dbz=%b q=%h r=%0d want 1 ffff 1234", div_by_zero, quotient, remainder);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== DONE_AFTER || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dbz_hold: got done=%b dbz=%b want %b 1", done, div_by_zero, DONE_AFTER);
    end
  endtask

  task automatic test_boundary();
    int e, b;
    run_div(16'd9, 16'd9, e, b);
    checks++;
    if (e !== 2 || quotient !== 16'd1 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL equal: got edges=%0d q=%0d r=%0d dbz=%b want 2 1 0 0", e, quotient, remainder, div_by_zero);
    end
    run_div(16'hFFFF, 16'd1, e, b);
    checks++;
    if (e !== 65536 || quotient !== 16'hFFFF || remainder !== 16'd0) begin
      failures++;
      $display("FAIL max: got edges=%0d q=%h r=%0d want 65536 ffff 0", e, quotient, remainder);
    end
  endtask

  task automatic test_abort();
    int e, b;
    @(negedge clk);
    dividend = 16'd200;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #2;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      failures++;
      $display("FAIL abort: got busy/done/dbz=%b q=%0d r=%0d want 000 0 0",
               {busy, done, div_by_zero}, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    run_div(16'd30, 16'd4, e, b);
    checks++;
    if (e !== 8 || quotient !== 16'd7 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL after_abort: got edges=%0d q=%0d r=%0d want 8 7 2", e, quotient, remainder);
    end
  endtask

  task automatic test_start_in_run();
    int e;
    @(negedge clk);
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    // Keep start asserted and scramble the operands while the division runs (well before DONE at edge 11).
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dividend = 16'($urandom_range(0, 65535));
      divisor  = 16'($urandom_range(0, 65535));
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL run_busy: got %b want 1", busy); end
    start = 1'b0;
    e = 0;
    while (!done && e < BUDGET) begin
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    checks++;
    if (done !== 1'b1 || quotient !== 16'd10 || remainder !== 16'd0) begin
      failures++;
      $display("FAIL start_in_run: got done=%b q=%0d r=%0d want 1 10 0", done, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int e, b;
    run_div(16'd20, 16'd6, e, b);
    checks++;
    if (e !== 4 || quotient !== 16'd3 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL b2b_first: got edges=%0d q=%0d r=%0d want 4 3 2", e, quotient, remainder);
    end
    // Issue the next start in the very cycle done is high.
    dividend = 16'd9;
    divisor  = 16'd2;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd9) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b done=%b q=%0d r=%0d want 1 0 0 9", busy, done, quotient, remainder);
    end
    e = 0;
    while (!done && e < BUDGET) begin
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    checks++;
    if (done !== 1'b1 || e !== 5 || quotient !== 16'd4 || remainder !== 16'd1) begin
      failures++;
      $display("FAIL b2b_second: got done=%b edges=%0d q=%0d r=%0d want 1 5 4 1", done, e, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small();
    test_div_zero();
    test_boundary();
    test_abort();
    test_start_in_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
